// File: rtl/fir_ctrl_if.sv
// AXI-Lite register bus, tap BRAM port and engine handshake bundled for fir_ctrl.
// slave is the controller's view; master is the host/BRAM/engine side.
interface fir_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    logic [3:0]             tap_WE;
    logic                   tap_EN;
    logic [pDATA_WIDTH-1:0] tap_Di;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic [pDATA_WIDTH-1:0] tap_Do;

    logic                   eng_tap_en;
    logic [pADDR_WIDTH-1:0] eng_tap_A;
    logic                   eng_start;
    logic                   eng_done;
    logic [31:0]            data_length;
    logic                   ap_idle;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               tap_Do, eng_tap_en, eng_tap_A, eng_done,
        output awready, wready, arready, rvalid, rdata,
               tap_WE, tap_EN, tap_Di, tap_A, eng_start, data_length, ap_idle
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               tap_Do, eng_tap_en, eng_tap_A, eng_done,
        input  awready, wready, arready, rvalid, rdata,
               tap_WE, tap_EN, tap_Di, tap_A, eng_start, data_length, ap_idle
    );
endinterface

// File: rtl/fir_ctrl.sv
// AXI-Lite register block and start/done sequencer for the FIR engine; owns the shared tap BRAM port.
// Writes commit one cycle after aw and w are both latched; read data appears one cycle after arready and holds until rready.
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tap_Num     = 11
) (
    input logic       axis_clk,
    input logic       axis_rst_n,
    fir_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'('h20);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'('h20 + 4 * (Tap_Num - 1));

    state_t                 state_q, state_d;
    logic                   aw_vld_q, aw_vld_d;
    logic [pADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                   w_vld_q, w_vld_d;
    logic [pDATA_WIDTH-1:0] w_dat_q, w_dat_d;
    logic                   rvalid_q, rvalid_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rd_tap_q, rd_tap_d;
    logic                   rd_ctrl_q, rd_ctrl_d;
    logic                   ap_start_q, ap_start_d;
    logic                   ap_done_q, ap_done_d;
    logic [31:0]            len_q, len_d;

    logic                   idle, commit, wr_tap, ar_tap, ar_acc;
    logic [pDATA_WIDTH-1:0] ctrl_word;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP0) && (a <= ADDR_TAPN) && (a[1:0] == 2'b00);
    endfunction

    assign idle      = (state_q == S_IDLE);
    assign commit    = aw_vld_q && w_vld_q;
    assign wr_tap    = commit && is_tap(aw_addr_q);
    assign ar_tap    = is_tap(bus.araddr);
    // A tap write commit in IDLE holds the BRAM port, so a tap read waits a cycle.
    assign ar_acc    = bus.arvalid && !rvalid_q && !(idle && wr_tap && ar_tap);
    assign ctrl_word = {{(pDATA_WIDTH-3){1'b0}}, idle, ap_done_q, ap_start_q};

    assign bus.awready     = commit;
    assign bus.wready      = commit;
    assign bus.arready     = ar_acc;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rd_tap_q ? bus.tap_Do : rdata_q;
    assign bus.data_length = len_q;

    always_comb begin
        state_d       = state_q;
        bus.eng_start = 1'b0;
        bus.ap_idle   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                if (ap_start_q) state_d = S_START;
            end
            S_START: begin
                bus.eng_start = 1'b1;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (bus.eng_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tap_WE = 4'h0;
        bus.tap_EN = 1'b0;
        bus.tap_A  = '0;
        bus.tap_Di = '0;
        if (!idle) begin
            bus.tap_EN = bus.eng_tap_en;
            bus.tap_A  = bus.eng_tap_A;
        end else if (wr_tap) begin
            bus.tap_WE = 4'hF;
            bus.tap_EN = 1'b1;
            bus.tap_A  = aw_addr_q - ADDR_TAP0;
            bus.tap_Di = w_dat_q;
        end else if (ar_acc && ar_tap) begin
            bus.tap_EN = 1'b1;
            bus.tap_A  = bus.araddr - ADDR_TAP0;
        end
    end

    always_comb begin
        aw_vld_d   = aw_vld_q;
        aw_addr_d  = aw_addr_q;
        w_vld_d    = w_vld_q;
        w_dat_d    = w_dat_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rd_tap_d   = rd_tap_q;
        rd_ctrl_d  = rd_ctrl_q;
        ap_start_d = ap_start_q;
        ap_done_d  = ap_done_q;
        len_d      = len_q;

        if (commit) begin
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
        end else begin
            if (bus.awvalid && !aw_vld_q) begin
                aw_vld_d  = 1'b1;
                aw_addr_d = bus.awaddr;
            end
            if (bus.wvalid && !w_vld_q) begin
                w_vld_d = 1'b1;
                w_dat_d = bus.wdata;
            end
        end

        if (commit && idle) begin
            if (aw_addr_q == ADDR_LEN)               len_d      = 32'(w_dat_q);
            if (aw_addr_q == ADDR_CTRL && w_dat_q[0]) ap_start_d = 1'b1;
        end
        if (state_q == S_START) ap_start_d = 1'b0;

        if (rvalid_q && bus.rready) begin
            rvalid_d = 1'b0;
            if (rd_ctrl_q) ap_done_d = 1'b0;
        end
        if (state_q == S_RUN && bus.eng_done) ap_done_d = 1'b1;

        // Tap data is passed straight through on its first cycle, then held locally.
        if (rd_tap_q) begin
            rdata_d  = bus.tap_Do;
            rd_tap_d = 1'b0;
        end
        if (ar_acc) begin
            rvalid_d  = 1'b1;
            rd_ctrl_d = (bus.araddr == ADDR_CTRL);
            rd_tap_d  = ar_tap && idle;
            if (ar_tap)                        rdata_d = idle ? '0 : '1;
            else if (bus.araddr == ADDR_CTRL)  rdata_d = ctrl_word;
            else if (bus.araddr == ADDR_LEN)   rdata_d = pDATA_WIDTH'(len_q);
            else                               rdata_d = '0;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            aw_vld_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_vld_q    <= 1'b0;
            w_dat_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rd_tap_q   <= 1'b0;
            rd_ctrl_q  <= 1'b0;
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            aw_vld_q   <= aw_vld_d;
            aw_addr_q  <= aw_addr_d;
            w_vld_q    <= w_vld_d;
            w_dat_q    <= w_dat_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rd_tap_q   <= rd_tap_d;
            rd_ctrl_q  <= rd_ctrl_d;
            ap_start_q <= ap_start_d;
            ap_done_q  <= ap_done_d;
            len_q      <= len_d;
        end
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// Directed and randomized bench for fir_ctrl: BRAM model plus an address-map reference model.
module tb_fir_ctrl;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int TAPS = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail   = 0;

    int cyc             = 0;
    int n_start         = 0;
    int n_we            = 0;
    int last_commit_cyc = 0;
    int last_start_cyc  = 0;

    logic [31:0] bram [64];
    logic [31:0] m_tap [TAPS];
    logic [31:0] m_len    = '0;
    bit          m_run    = 1'b0;
    bit          m_done   = 1'b0;
    int          m_starts = 0;

    logic [3:0]    wr_we;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_di;

    int coef [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [AW-1:0] unmapped [5] = '{12'h004, 12'h014, 12'h04C, 12'h022, 12'h800};

    fir_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tap_Num(TAPS)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.awready) last_commit_cyc <= cyc;
        if (bus.eng_start) begin
            n_start        <= n_start + 1;
            last_start_cyc <= cyc;
        end
        if (bus.tap_WE != 4'h0) n_we <= n_we + 1;
    end

    always @(posedge clk) begin
        if (bus.tap_EN) begin
            for (int b = 0; b < 4; b++)
                if (bus.tap_WE[b]) bram[bus.tap_A[7:2]][8*b +: 8] <= bus.tap_Di[8*b +: 8];
            bus.tap_Do <= bram[bus.tap_A[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int tap_idx(input logic [AW-1:0] a);
        int off = int'(a) - 32;
        if (off < 0 || off % 4 != 0 || off / 4 >= TAPS) return -1;
        return off / 4;
    endfunction

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        int k = tap_idx(a);
        if (k >= 0) return m_run ? 32'hFFFF_FFFF : m_tap[k];
        if (a == 12'h000) return 32'((m_run ? 0 : 4) + (m_done ? 2 : 0));
        if (a == 12'h010) return m_len;
        return 32'h0;
    endfunction

    task automatic model_wr(input logic [AW-1:0] a, input logic [31:0] d);
        int k = tap_idx(a);
        if (m_run) return;
        if (k >= 0) m_tap[k] = d;
        else if (a == 12'h010) m_len = d;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        int n = 0;
        @(posedge clk); #1;
        bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        while (!bus.awready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_awready"}, 32'(bus.awready), 32'd1);
        chk({tag, "_wready"}, 32'(bus.wready), 32'd1);
        wr_we = bus.tap_WE; wr_a = bus.tap_A; wr_di = bus.tap_Di;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_drop"}, 32'({bus.awready, bus.wready}), 32'd0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold, input string tag);
        int n = 0;
        logic [31:0] exp;
        exp = model_rd(a);
        @(posedge clk); #1;
        bus.araddr = a; bus.arvalid = 1'b1;
        @(negedge clk);
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_arready"}, 32'(bus.arready), 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        chk({tag, "_rdata"}, bus.rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_rvalid"}, 32'(bus.rvalid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.rdata, exp);
        end
        @(posedge clk); #1; bus.rready = 1'b1;
        @(posedge clk); #1; bus.rready = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid_drop"}, 32'(bus.rvalid), 32'd0);
        if (a == 12'h000) m_done = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        int we_before;

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        bus.eng_tap_en = 1'b0; bus.eng_tap_A = '0; bus.eng_done = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ap_idle", 32'(bus.ap_idle), 32'd1);
        chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
        chk("rst_data_length", bus.data_length, 32'd0);
        chk("rst_handshake", 32'({bus.awready, bus.wready, bus.arready, bus.rvalid}), 32'd0);
        chk("rst_tap_port", 32'({bus.tap_EN, bus.tap_WE}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        axi_read(12'h000, 0, "rd_ctrl_rst");

        axi_write(12'h010, 32'd600, "wr_len");
        m_len = 32'd600;
        chk("len_600", bus.data_length, 32'd600);
        axi_read(12'h010, 1, "rd_len");

        for (int k = 0; k < TAPS; k++) begin
            axi_write(12'(32 + 4 * k), 32'(coef[k]), "wr_tap");
            chk("wr_tap_we", 32'(wr_we), 32'hF);
            chk("wr_tap_a", 32'(wr_a), 32'(4 * k));
            chk("wr_tap_di", wr_di, 32'(coef[k]));
            m_tap[k] = 32'(coef[k]);
        end
        for (int k = 0; k < TAPS; k++) axi_read(12'(32 + 4 * k), k % 3, "rd_tap");

        // Start: pulse two cycles after commit, exactly one cycle wide
        axi_write(12'h000, 32'h1, "wr_start");
        m_starts++; m_run = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_delay", 32'(last_start_cyc - last_commit_cyc), 32'd2);
        chk("start_pulses", 32'(n_start), 32'(m_starts));
        chk("run_ap_idle", 32'(bus.ap_idle), 32'd0);
        axi_read(12'h000, 0, "rd_ctrl_run");

        // Engine owns the tap port during RUN
        @(posedge clk); #1;
        bus.eng_tap_en = 1'b1; bus.eng_tap_A = 12'h008;
        @(negedge clk);
        chk("run_tap_a", 32'(bus.tap_A), 32'h8);
        chk("run_tap_en", 32'(bus.tap_EN), 32'd1);
        chk("run_tap_we", 32'(bus.tap_WE), 32'd0);
        we_before = n_we;
        axi_write(12'h024, 32'd99, "wr_tap_run");
        model_wr(12'h024, 32'd99);
        chk("run_tap_wr_dropped", 32'(wr_we), 32'd0);
        chk("run_we_count", 32'(n_we), 32'(we_before));
        axi_read(12'h024, 1, "rd_tap_run");
        axi_write(12'h010, 32'd5, "wr_len_run");
        model_wr(12'h010, 32'd5);
        chk("run_len_kept", bus.data_length, m_len);
        axi_write(12'h000, 32'h1, "wr_start_run");
        @(posedge clk); #1;
        bus.eng_tap_en = 1'b0;

        @(posedge clk); #1; bus.eng_done = 1'b1;
        @(posedge clk); #1; bus.eng_done = 1'b0;
        m_run = 1'b0; m_done = 1'b1;
        @(negedge clk);
        chk("done_ap_idle", 32'(bus.ap_idle), 32'd1);
        repeat (4) @(negedge clk);
        chk("no_start_from_run_write", 32'(n_start), 32'(m_starts));
        axi_read(12'h000, 0, "rd_ctrl_done");
        axi_read(12'h000, 0, "rd_ctrl_cleared");
        axi_read(12'h024, 0, "rd_tap_after_run");

        // Tap write and tap read colliding in IDLE: write first, read sees new value
        v = $urandom;
        @(posedge clk); #1;
        bus.awaddr = 12'h030; bus.wdata = v; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.araddr = 12'h030; bus.arvalid = 1'b1;
        @(negedge clk);
        chk("conf_awready", 32'(bus.awready), 32'd1);
        chk("conf_arready_held", 32'(bus.arready), 32'd0);
        chk("conf_tap_we", 32'(bus.tap_WE), 32'hF);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        m_tap[4] = v;
        chk("conf_arready", 32'(bus.arready), 32'd1);
        chk("conf_tap_en", 32'(bus.tap_EN), 32'd1);
        chk("conf_tap_a", 32'(bus.tap_A), 32'h10);
        @(posedge clk); #1; bus.arvalid = 1'b0;
        @(negedge clk);
        chk("conf_rvalid", 32'(bus.rvalid), 32'd1);
        chk("conf_rdata", bus.rdata, model_rd(12'h030));
        @(posedge clk); #1; bus.rready = 1'b1;
        @(posedge clk); #1; bus.rready = 1'b0;

        // ap_done set wins over a simultaneous clearing read
        axi_write(12'h000, 32'h1, "wr_start2");
        m_starts++; m_run = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.araddr = 12'h000; bus.arvalid = 1'b1;
        @(negedge clk);
        chk("coinc_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1; bus.arvalid = 1'b0;
        @(negedge clk);
        chk("coinc_rdata", bus.rdata, model_rd(12'h000));
        @(posedge clk); #1; bus.rready = 1'b1; bus.eng_done = 1'b1;
        @(posedge clk); #1; bus.rready = 1'b0; bus.eng_done = 1'b0;
        m_run = 1'b0; m_done = 1'b1;
        @(negedge clk);
        chk("coinc_rvalid_drop", 32'(bus.rvalid), 32'd0);
        axi_read(12'h000, 0, "rd_ctrl_coinc");
        axi_read(12'h000, 0, "rd_ctrl_coinc2");

        // Reset while running: back to IDLE, no further start pulse, taps retained
        axi_write(12'h000, 32'h1, "wr_start3");
        m_starts++;
        repeat (4) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        m_run = 1'b0; m_done = 1'b0; m_len = '0;
        @(negedge clk);
        chk("rstrun_ap_idle", 32'(bus.ap_idle), 32'd1);
        chk("rstrun_len", bus.data_length, m_len);
        repeat (4) @(negedge clk);
        chk("rstrun_starts", 32'(n_start), 32'(m_starts));
        axi_read(12'h000, 0, "rd_ctrl_rstrun");
        axi_read(12'h02C, 0, "rd_tap_rstrun");

        axi_write(12'h010, 32'd0, "wr_len_zero");
        chk("len_zero", bus.data_length, 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 12'h010;
                1, 2:    a = 12'(32 + 4 * $urandom_range(0, TAPS - 1));
                default: a = ($urandom_range(0, 2) == 0) ? 12'h000 : unmapped[$urandom_range(0, 4)];
            endcase
            if ($urandom_range(0, 1) == 1 && a != 12'h000) begin
                v = $urandom;
                axi_write(a, v, "rnd_wr");
                model_wr(a, v);
            end else begin
                axi_read(a, $urandom_range(0, 2), "rnd_rd");
            end
        end
        chk("rnd_len_final", bus.data_length, m_len);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
